// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared types and constants for the host-channel read path
//
// Purpose: request command encoding, field widths and line data type used by
// hc_read_responder and hc_read_rob.
// Contents:
//   HC_NUM_BUFFERS       buffer ids carried by t_buffer_total_size
//   HC_MAX_BUFFER_SIZE   bit width of one per-id size field (lines)
//   HC_MAX_OUTSTANDING   largest supported number of reads in flight
//   t_request_cmd / _id / _offset, t_request_size, t_buffer_data,
//   t_buffer_total_size, is_read_cmd()
package hc_pkg;

  localparam int HC_NUM_BUFFERS     = 4;
  localparam int HC_MAX_BUFFER_SIZE = 16;
  localparam int HC_MAX_OUTSTANDING = 16;
  localparam int HC_LINE_BITS       = 512;

  typedef enum logic [1:0] {
    e_REQUEST_NONE         = 2'd0,
    e_REQUEST_READ_STREAM  = 2'd1,
    e_REQUEST_READ_INDEXED = 2'd2,
    e_REQUEST_WRITE        = 2'd3
  } t_request_cmd;

  // Wider than log2(HC_NUM_BUFFERS) so out-of-range ids can be seen and rejected.
  typedef logic [3:0]                                  t_request_cmd_id;
  typedef logic [HC_MAX_BUFFER_SIZE-1:0]               t_request_cmd_offset;
  // One extra bit so a completely full window (== HC_MAX_OUTSTANDING) fits.
  typedef logic [$clog2(HC_MAX_OUTSTANDING):0]         t_request_size;
  typedef logic [HC_LINE_BITS-1:0]                     t_buffer_data;
  typedef logic [HC_NUM_BUFFERS*HC_MAX_BUFFER_SIZE-1:0] t_buffer_total_size;

  function automatic logic is_read_cmd(input t_request_cmd cmd);
    return (cmd == e_REQUEST_READ_STREAM) || (cmd == e_REQUEST_READ_INDEXED);
  endfunction

endpackage

// File: rtl/hc_read_rob.sv
// rtl/hc_read_rob.sv - tag-indexed reorder buffer for read responses
//
// Purpose: responses are written at the slot named by their tag and released
// strictly in tag (issue) order from a head pointer.  A response that lands
// on the current head slot is released in the same cycle (bypass), so the
// head can reach rx one cycle after it arrives.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   wr_valid/tag/data  response write port
//   head_valid/data    combinational in-order release; a release pops the head
module hc_read_rob
  import hc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  t_buffer_data     wr_data,
  output logic             head_valid,
  output t_buffer_data     head_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] head_q, head_d;
  t_buffer_data     data_q [DEPTH];
  logic             hit_stored;
  logic             hit_bypass;

  always_comb begin
    hit_stored = valid_q[head_q];
    hit_bypass = wr_valid && (wr_tag == head_q);
    head_valid = hit_stored || hit_bypass;
    head_data  = hit_stored ? data_q[head_q] : wr_data;

    valid_d = valid_q;
    if (wr_valid) valid_d[wr_tag] = 1'b1;
    // Clearing after setting covers the bypass case: the slot never lingers.
    if (head_valid) valid_d[head_q] = 1'b0;

    head_d = head_q + TAG_W'(head_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (wr_valid) data_q[wr_tag] <= wr_data;
  end

endmodule

// File: rtl/hc_read_responder.sv
// rtl/hc_read_responder.sv - read-request front end: address gen, tags, response delivery
//
// Purpose: accepts stream/indexed read commands per buffer id, range-checks
// them against the per-id size, issues one registered memory read per
// accepted command with a free-running tag, tracks reads in flight and
// delivers returned lines on rx as one-cycle pulses.
// Optional feature macro: HC_READ_REORDER_EN - deliver rx in issue order via
// hc_read_rob; when undefined, responses are forwarded in arrival order.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   req_cmd, req_id, req_offset         read request control fields
//   status_count/empty/full             reads issued but not yet delivered
//   buf_base, buffer_size               per-id base line address / size in lines
//   mem_rd_valid/addr/tag, mem_almfull  memory read request channel
//   mem_rsp_valid/tag/data              memory read response channel
//   rx_valid, rx_data                   delivered lines (no backpressure)
//   err_range                           sticky out-of-range command flag
module hc_read_responder
  import hc_pkg::*;
#(
  parameter int NUM_BUFFERS     = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ADDR_WIDTH      = 42
) (
  input  logic                              clk,
  input  logic                              reset,
  input  t_request_cmd                      req_cmd,
  input  t_request_cmd_id                   req_id,
  input  t_request_cmd_offset               req_offset,
  output t_request_size                     status_count,
  output logic                              status_empty,
  output logic                              status_full,
  input  logic [NUM_BUFFERS*ADDR_WIDTH-1:0] buf_base,
  input  t_buffer_total_size                buffer_size,
  output logic                              mem_rd_valid,
  output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
  output logic [$clog2(MAX_OUTSTANDING)-1:0] mem_rd_tag,
  input  logic                              mem_almfull,
  input  logic                              mem_rsp_valid,
  input  logic [$clog2(MAX_OUTSTANDING)-1:0] mem_rsp_tag,
  input  t_buffer_data                      mem_rsp_data,
  output logic                              rx_valid,
  output t_buffer_data                      rx_data,
  output logic                              err_range
);

  localparam int            TAG_W   = $clog2(MAX_OUTSTANDING);
  localparam int            PTR_W   = HC_MAX_BUFFER_SIZE;
  localparam t_request_size CNT_MAX = t_request_size'(MAX_OUTSTANDING);

  // Registered state
  logic                  mem_rd_valid_q, mem_rd_valid_d;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_q,  mem_rd_addr_d;
  logic [TAG_W-1:0]      mem_rd_tag_q,   mem_rd_tag_d;
  logic [TAG_W-1:0]      tag_cnt_q,      tag_cnt_d;
  logic [PTR_W-1:0]      stream_ptr_q [NUM_BUFFERS];
  logic [PTR_W-1:0]      stream_ptr_d [NUM_BUFFERS];
  logic                  err_range_q,    err_range_d;
  t_request_size         count_q,        count_d;
  logic                  status_empty_q, status_empty_d;
  logic                  status_full_q,  status_full_d;
  logic                  rx_valid_q,     rx_valid_d;
  t_buffer_data          rx_data_q,      rx_data_d;

  // Request decode
  logic                  sel_hit;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [PTR_W-1:0]      sel_size;
  logic [PTR_W-1:0]      sel_ptr;
  logic [PTR_W-1:0]      line_idx;
  logic                  is_stream;
  logic                  in_range;
  logic                  cmd_take;
  logic                  issue;
  logic                  rsp_accept;
  logic                  deliver_valid;
  t_buffer_data          deliver_data;

  // Per-id lookup by comparison so an id beyond NUM_BUFFERS simply misses.
  always_comb begin
    sel_hit  = 1'b0;
    sel_base = '0;
    sel_size = '0;
    sel_ptr  = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (req_id == t_request_cmd_id'(i)) begin
        sel_hit  = 1'b1;
        sel_base = buf_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size = buffer_size[i*HC_MAX_BUFFER_SIZE +: HC_MAX_BUFFER_SIZE];
        sel_ptr  = stream_ptr_q[i];
      end
    end
  end

  always_comb begin
    is_stream = (req_cmd == e_REQUEST_READ_STREAM);
    line_idx  = is_stream ? sel_ptr : req_offset;
    in_range  = sel_hit && (line_idx < sel_size);
    // Blocked commands are dropped outright; there is no request queue.
    cmd_take  = is_read_cmd(req_cmd) && !status_full_q && !mem_almfull;
    issue     = cmd_take && in_range;
    // A response with nothing in flight is stale (e.g. from before a reset).
    rsp_accept = mem_rsp_valid && (count_q != '0);
  end

`ifdef HC_READ_REORDER_EN
  hc_read_rob #(
    .DEPTH (MAX_OUTSTANDING),
    .TAG_W (TAG_W)
  ) u_rob (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (rsp_accept),
    .wr_tag     (mem_rsp_tag),
    .wr_data    (mem_rsp_data),
    .head_valid (deliver_valid),
    .head_data  (deliver_data)
  );
`else
  logic unused_rsp_tag;
  assign unused_rsp_tag = ^mem_rsp_tag;
  assign deliver_valid  = rsp_accept;
  assign deliver_data   = mem_rsp_data;
`endif

  always_comb begin
    mem_rd_valid_d = issue;
    mem_rd_addr_d  = issue ? (sel_base + ADDR_WIDTH'(line_idx)) : mem_rd_addr_q;
    mem_rd_tag_d   = issue ? tag_cnt_q : mem_rd_tag_q;
    // Power-of-two depth: natural wrap gives the modulo.
    tag_cnt_d      = tag_cnt_q + TAG_W'(issue);

    stream_ptr_d = stream_ptr_q;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (issue && is_stream && (req_id == t_request_cmd_id'(i))) begin
        stream_ptr_d[i] = stream_ptr_q[i] + PTR_W'(1);
      end
    end

    err_range_d = err_range_q || (cmd_take && !in_range);

    case ({issue, deliver_valid})
      2'b10:   count_d = count_q + t_request_size'(1);
      2'b01:   count_d = count_q - t_request_size'(1);
      default: count_d = count_q;
    endcase
    // Flags follow count_d so they line up with status_count every cycle.
    status_empty_d = (count_d == '0);
    status_full_d  = (count_d == CNT_MAX);

    rx_valid_d = deliver_valid;
    rx_data_d  = deliver_valid ? deliver_data : rx_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
      mem_rd_tag_q   <= '0;
      tag_cnt_q      <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) stream_ptr_q[i] <= '0;
      err_range_q    <= 1'b0;
      count_q        <= '0;
      status_empty_q <= 1'b1;
      status_full_q  <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
    end else begin
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_rd_tag_q   <= mem_rd_tag_d;
      tag_cnt_q      <= tag_cnt_d;
      stream_ptr_q   <= stream_ptr_d;
      err_range_q    <= err_range_d;
      count_q        <= count_d;
      status_empty_q <= status_empty_d;
      status_full_q  <= status_full_d;
      rx_valid_q     <= rx_valid_d;
      rx_data_q      <= rx_data_d;
    end
  end

  assign mem_rd_valid = mem_rd_valid_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign mem_rd_tag   = mem_rd_tag_q;
  assign err_range    = err_range_q;
  assign status_count = count_q;
  assign status_empty = status_empty_q;
  assign status_full  = status_full_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;

endmodule

// File: tb/tb_hc_read_responder.sv
// tb/tb_hc_read_responder.sv - scoreboard bench for hc_read_responder
module tb_hc_read_responder;
  import hc_pkg::*;

  localparam int NB = 4;
  localparam int MO = 16;
  localparam int AW = 42;
  localparam int TW = 4;

  logic                clk = 1'b0;
  logic                reset;
  t_request_cmd        req_cmd;
  t_request_cmd_id     req_id;
  t_request_cmd_offset req_offset;
  t_request_size       status_count;
  logic                status_empty;
  logic                status_full;
  logic [NB*AW-1:0]    buf_base;
  t_buffer_total_size  buffer_size;
  logic                mem_rd_valid;
  logic [AW-1:0]       mem_rd_addr;
  logic [TW-1:0]       mem_rd_tag;
  logic                mem_almfull;
  logic                mem_rsp_valid;
  logic [TW-1:0]       mem_rsp_tag;
  t_buffer_data        mem_rsp_data;
  logic                rx_valid;
  t_buffer_data        rx_data;
  logic                err_range;

  always #5 clk = ~clk;

  hc_read_responder #(
    .NUM_BUFFERS     (NB),
    .MAX_OUTSTANDING (MO),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_cmd       (req_cmd),
    .req_id        (req_id),
    .req_offset    (req_offset),
    .status_count  (status_count),
    .status_empty  (status_empty),
    .status_full   (status_full),
    .buf_base      (buf_base),
    .buffer_size   (buffer_size),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_tag    (mem_rd_tag),
    .mem_almfull   (mem_almfull),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_tag   (mem_rsp_tag),
    .mem_rsp_data  (mem_rsp_data),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .err_range     (err_range)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } rd_exp_t;

  int checks   = 0;
  int failures = 0;

  rd_exp_t      exp_rd [$];
  t_buffer_data exp_rx [$];
  int           out_tags [$];
  logic         pend_v [MO];
  t_buffer_data pend_d [MO];
  int           m_count;
  int           m_tag;
  int           m_ptr [NB];
  int           salt;
  logic [AW-1:0] base_a [NB];
  int           size_a [NB];
  rd_exp_t      mon_e;
  t_buffer_data mon_d;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic t_buffer_data mk_data(input int tag, input int s);
    t_buffer_data d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = 32'hA500_0000 ^ (s << 12) ^ (w << 8) ^ tag;
    return d;
  endfunction

  task automatic set_idle();
    req_cmd       = e_REQUEST_NONE;
    req_id        = '0;
    req_offset    = '0;
    mem_almfull   = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_tag   = '0;
    mem_rsp_data  = '0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected rx ordering: arrival order, or issue order with the reorder buffer.
  task automatic model_response(input int tag);
`ifdef HC_READ_REORDER_EN
    pend_v[tag] = 1'b1;
    pend_d[tag] = mk_data(tag, salt);
    while (out_tags.size() > 0 && pend_v[out_tags[0]]) begin
      exp_rx.push_back(pend_d[out_tags[0]]);
      pend_v[out_tags[0]] = 1'b0;
      void'(out_tags.pop_front());
    end
`else
    exp_rx.push_back(mk_data(tag, salt));
    for (int i = 0; i < out_tags.size(); i++) begin
      if (out_tags[i] == tag) begin
        out_tags.delete(i);
        break;
      end
    end
`endif
  endtask

  // One clock of stimulus: optional command plus optional response.
  task automatic drive_cycle(input t_request_cmd cmd, input int id, input int off,
                             input logic almf, input logic rv, input int rtag);
    logic    acc;
    logic    in_rng;
    logic    rok;
    int      idx;
    rd_exp_t e;
    req_cmd       = cmd;
    req_id        = t_request_cmd_id'(id);
    req_offset    = t_request_cmd_offset'(off);
    mem_almfull   = almf;
    mem_rsp_valid = rv;
    mem_rsp_tag   = TW'(rtag);
    mem_rsp_data  = mk_data(rtag, salt);

    acc    = (cmd == e_REQUEST_READ_STREAM || cmd == e_REQUEST_READ_INDEXED) && (m_count < MO) && !almf;
    in_rng = 1'b0;
    idx    = off;
    if (id < NB) begin
      if (cmd == e_REQUEST_READ_STREAM) idx = m_ptr[id];
      in_rng = (idx < size_a[id]);
    end
    rok = rv && (m_count != 0);

    if (acc && in_rng) begin
      e.addr = base_a[id] + AW'(idx);
      e.tag  = TW'(m_tag);
      exp_rd.push_back(e);
      out_tags.push_back(m_tag);
      if (cmd == e_REQUEST_READ_STREAM) m_ptr[id]++;
      m_tag = (m_tag + 1) % MO;
    end
    if (rok) model_response(rtag);
    m_count = m_count + ((acc && in_rng) ? 1 : 0) - (rok ? 1 : 0);

    @(posedge clk);
    #1;
    if (acc && in_rng) check_eq("rd_valid_at_n1", mem_rd_valid, 1);
`ifndef HC_READ_REORDER_EN
    if (rok) check_eq("rx_valid_at_m1", rx_valid, 1);
`endif
    set_idle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    set_idle();
    exp_rd.delete();
    exp_rx.delete();
    out_tags.delete();
    m_count = 0;
    m_tag   = 0;
    for (int i = 0; i < NB; i++) m_ptr[i] = 0;
    for (int i = 0; i < MO; i++) pend_v[i] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_rd_valid", mem_rd_valid, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_count", status_count, 0);
    check_eq("rst_empty", status_empty, 1);
    check_eq("rst_full", status_full, 0);
    check_eq("rst_err", err_range, 0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_valid) begin
        if (exp_rd.size() == 0) begin
          check_eq("rd_unexpected", mem_rd_valid, 0);
        end else begin
          mon_e = exp_rd.pop_front();
          check_eq("rd_addr", mem_rd_addr, mon_e.addr);
          check_eq("rd_tag", mem_rd_tag, mon_e.tag);
        end
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          check_eq("rx_unexpected", rx_valid, 0);
        end else begin
          mon_d = exp_rx.pop_front();
          check_eq("rx_data", rx_data, mon_d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    base_a[0] = 42'h000; size_a[0] = 4;
    base_a[1] = 42'h100; size_a[1] = 8;
    base_a[2] = 42'h200; size_a[2] = 32;
    base_a[3] = 42'h300; size_a[3] = 32;
    for (int i = 0; i < NB; i++) begin
      buf_base[i*AW +: AW] = base_a[i];
      buffer_size[i*HC_MAX_BUFFER_SIZE +: HC_MAX_BUFFER_SIZE] = HC_MAX_BUFFER_SIZE'(size_a[i]);
    end
    salt = 0;
    set_idle();

    do_reset(3);
    idle(1);
    check_eq("post_rst_empty", status_empty, 1);
    check_eq("post_rst_count", status_count, 0);

    // Three stream reads on id 1: 0x100..0x102, tags 0..2.
    repeat (3) drive_cycle(e_REQUEST_READ_STREAM, 1, 0, 1'b0, 1'b0, 0);
    idle(2);
    check_eq("count_3", status_count, 3);
    check_eq("empty_at_3", status_empty, 0);

    // Indexed past the end of id 0: dropped, sticky error.
    drive_cycle(e_REQUEST_READ_INDEXED, 0, 5, 1'b0, 1'b0, 0);
    idle(1);
    check_eq("err_range_set", err_range, 1);
    check_eq("count_after_err", status_count, 3);

    // Bad id, non-read command, almfull-blocked command: none issue.
    drive_cycle(e_REQUEST_READ_STREAM, 5, 0, 1'b0, 1'b0, 0);
    drive_cycle(e_REQUEST_WRITE, 1, 0, 1'b0, 1'b0, 0);
    drive_cycle(e_REQUEST_READ_STREAM, 1, 0, 1'b1, 1'b0, 0);
    idle(2);
    check_eq("count_after_drops", status_count, 3);

    // Responses in tag order 2,0,1.
    salt = 1;
    drive_cycle(e_REQUEST_NONE, 0, 0, 1'b0, 1'b1, 2);
    drive_cycle(e_REQUEST_NONE, 0, 0, 1'b0, 1'b1, 0);
    drive_cycle(e_REQUEST_NONE, 0, 0, 1'b0, 1'b1, 1);
    idle(5);
    check_eq("count_drained", status_count, 0);
    check_eq("empty_drained", status_empty, 1);

    // Stream pointer untouched by the drops; boundary lines of id 1 and id 0.
    drive_cycle(e_REQUEST_READ_STREAM, 1, 0, 1'b0, 1'b0, 0);
    drive_cycle(e_REQUEST_READ_INDEXED, 1, 7, 1'b0, 1'b0, 0);
    drive_cycle(e_REQUEST_READ_INDEXED, 1, 8, 1'b0, 1'b0, 0);
    repeat (5) drive_cycle(e_REQUEST_READ_STREAM, 0, 0, 1'b0, 1'b0, 0);
    idle(2);
    check_eq("err_sticky", err_range, 1);
    check_eq("count_6", status_count, 6);

    salt = 2;
    drive_cycle(e_REQUEST_NONE, 0, 0, 1'b0, 1'b1, out_tags[0]);
    idle(3);
    check_eq("count_5", status_count, 5);

    // Issue and delivery in the same cycle leave the count alone.
    drive_cycle(e_REQUEST_READ_INDEXED, 2, 0, 1'b0, 1'b1, out_tags[0]);
    check_eq("count_same_cycle", status_count, 5);
    idle(1);
    check_eq("count_hold", status_count, 5);

    for (int k = 0; k < 20 && out_tags.size() > 0; k++)
      drive_cycle(e_REQUEST_NONE, 0, 0, 1'b0, 1'b1, out_tags[0]);
    idle(4);
    check_eq("count_drain2", status_count, 0);
    check_eq("empty_drain2", status_empty, 1);

    // Fill the window, then one more command must not issue.
    for (int i = 0; i < 16; i++) drive_cycle(e_REQUEST_READ_INDEXED, 2, i, 1'b0, 1'b0, 0);
    idle(2);
    check_eq("full_at_16", status_full, 1);
    check_eq("count_16", status_count, 16);
    drive_cycle(e_REQUEST_READ_INDEXED, 2, 20, 1'b0, 1'b0, 0);
    idle(2);
    check_eq("full_hold", status_full, 1);
    check_eq("rd_queue_idle", exp_rd.size(), 0);

    // Reset with reads in flight; late responses must be ignored.
    do_reset(2);
    repeat (4) drive_cycle(e_REQUEST_READ_STREAM, 1, 0, 1'b0, 1'b0, 0);
    idle(3);
    check_eq("count_4_pre_rst", status_count, 4);
    do_reset(2);
    salt = 3;
    for (int t = 0; t < 4; t++) drive_cycle(e_REQUEST_NONE, 0, 0, 1'b0, 1'b1, t);
    idle(3);
    check_eq("late_empty", status_empty, 1);
    check_eq("late_count", status_count, 0);
    check_eq("late_rx_valid", rx_valid, 0);

    idle(2);
    check_eq("rd_left", exp_rd.size(), 0);
    check_eq("rx_left", exp_rx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc_read_responder.md
HC_READ_RESPONDER -- requirements
Module: hc_read_responder

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 4, number of buffer ids served.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16 (power of two), max reads in flight.
REQ-003 SHALL have parameter ADDR_WIDTH, default 42, cache-line address width.
REQ-004 SHALL have ports: clk in 1, the sole clock; reset in 1, synchronous active-high.
REQ-005 SHALL have ports: req_cmd in t_request_cmd; req_id in t_request_cmd_id; req_offset in t_request_cmd_offset; these are the consumed read-request control fields.
REQ-006 SHALL have ports: status_count out t_request_size; status_empty out 1; status_full out 1; these form the read-request status returned to the user.
REQ-007 SHALL have ports: buf_base in NUM_BUFFERS*ADDR_WIDTH, per-id base line address; buffer_size in t_buffer_total_size, per-id size in lines, packed at id*HC_MAX_BUFFER_SIZE.
REQ-008 SHALL have ports: mem_rd_valid out 1; mem_rd_addr out ADDR_WIDTH; mem_rd_tag out log2(MAX_OUTSTANDING); mem_almfull in 1.
REQ-009 SHALL have ports: mem_rsp_valid in 1; mem_rsp_tag in log2(MAX_OUTSTANDING); mem_rsp_data in t_buffer_data.
REQ-010 SHALL have ports: rx_valid out 1; rx_data out t_buffer_data; err_range out 1, sticky.

Function
REQ-011 SHALL accept a command in a cycle when req_cmd is e_REQUEST_READ_STREAM or e_REQUEST_READ_INDEXED, status_full=0 and mem_almfull=0; other cmds are ignored and blocked cmds are dropped, not queued.
REQ-012 SHALL compute the address for stream commands as base[id]+stream_ptr[id], then post-increment stream_ptr[id].
REQ-013 SHALL compute the address for indexed commands as base[id]+req_offset, leaving stream_ptr unchanged.
REQ-014 SHALL, when the line index >= size(id), or id >= NUM_BUFFERS, discard the command, issue no read, not advance stream_ptr, and set err_range.
REQ-015 SHALL, on an accepted command in cycle N, assert mem_rd_valid for exactly one cycle at N+1 with a registered address and a tag from a free-running tag counter mod MAX_OUTSTANDING.
REQ-016 SHALL define status_count as reads issued but not yet delivered on rx; +1 on issue, -1 on delivery, unchanged on both in the same cycle.
REQ-017 SHALL drive status_empty = (count==0) and status_full = (count==MAX_OUTSTANDING), both registered from count.
REQ-018 SHALL, when mem_rsp_valid is high in cycle M, assert rx_valid with data no earlier than M+1; rx_valid is a one-cycle pulse per line, with no backpressure.
REQ-019 SHALL ignore a mem_rsp_valid with no read outstanding and leave count unchanged.

Reset
REQ-020 SHALL, during reset, hold mem_rd_valid=0, rx_valid=0, rx_data=0, status_count=0, status_empty=1, status_full=0, err_range=0, all stream_ptr=0, and tag counter=0.
REQ-021 SHALL, on reset asserted mid-operation, discard all in-flight reads, ignore late responses (count stays 0), and require no drain.

Configuration
REQ-022 SHALL, with HC_READ_REORDER_EN defined, write responses into a tag-indexed reorder buffer and deliver them on rx in issue order, with head delivered at M+1 at the earliest.
REQ-023 SHALL, without HC_READ_REORDER_EN, forward responses in arrival order at exactly M+1 and instantiate no reorder storage.

Structure
REQ-024 SHALL place t_request_cmd, t_request_cmd_id, t_request_cmd_offset, t_request_size, t_buffer_data, HC_MAX_BUFFER_SIZE and a new HC_MAX_OUTSTANDING constant in hc_pkg.
REQ-025 SHALL implement the reorder buffer as sub-module hc_read_rob (write port by tag, in-order read head, per-entry valid bit), instantiated only under HC_READ_REORDER_EN.

Verification
REQ-026 SHALL cover: reset, then 3 READ_STREAM id=1 with base[1]=0x100 and size=8 -> mem_rd_addr 0x100,0x101,0x102, tags 0,1,2, count=3.
REQ-027 SHALL cover: READ_INDEXED id=0 offset=5 with size(0)=4 -> no mem_rd_valid, err_range=1, count unchanged.
REQ-028 SHALL cover: 16 accepted reads with no responses -> status_full=1, and a 17th command produces no mem_rd_valid.
REQ-029 SHALL cover: with REORDER_EN, responses returned in tag order 2,0,1 -> rx delivers data of tags 0,1,2 in order; without it -> rx order 2,0,1.
REQ-030 SHALL cover: issue and response in the same cycle with count=5 -> count stays 5.
REQ-031 SHALL cover: reset with 4 reads outstanding, then 4 responses -> rx_valid stays 0, status_empty=1.
